// File: rtl/nb_info_line_buf_pkg.sv
// rtl/nb_info_line_buf_pkg.sv - shared state encodings for the neighbour info line buffer
package nb_info_line_buf_pkg;

  typedef enum logic [1:0] {
    NB_CLEAR = 2'd0,
    NB_IDLE  = 2'd1
  } nb_state_e;

endpackage

// File: rtl/ram_simple_dual.sv
// rtl/ram_simple_dual.sv - simple dual-port RAM, write port A, registered read port B (read-first)
module ram_simple_dual #(
  parameter int addr_bits = 8,
  parameter int data_bits = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [addr_bits-1:0] addra,
  input  logic [addr_bits-1:0] addrb,
  input  logic [data_bits-1:0] dia,
  output logic [data_bits-1:0] dob
);

  logic [data_bits-1:0] r_mem [1<<addr_bits];

  // Same-address read and write in one cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addra] <= dia;
      end
      dob <= r_mem[addrb];
    end
  end

endmodule

// File: rtl/nb_info_line_buf.sv
// rtl/nb_info_line_buf.sv - one line of per-4x4 neighbour info with clear sweep,
// busy flag and a 1-cycle read port with read-after-write bypass
module nb_info_line_buf
  import nb_info_line_buf_pkg::*;
#(
  parameter int                   addr_bits = 8,
  parameter int                   data_bits = 16,
  parameter logic [data_bits-1:0] clear_val = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_start,
  output logic                 busy,
  input  logic                 wr_en,
  input  logic [addr_bits-1:0] wr_addr,
  input  logic [data_bits-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [addr_bits-1:0] rd_addr,
  output logic                 rd_valid,
  output logic [data_bits-1:0] rd_data
);

  nb_state_e            r_state, w_state_nxt;
  logic [addr_bits-1:0] r_cnt, w_cnt_nxt;
  logic                 r_rd_valid;
  logic                 r_fwd;
  logic [data_bits-1:0] r_fwd_data;

  logic                 w_clear;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_ram_we;
  logic [addr_bits-1:0] w_ram_addra;
  logic [data_bits-1:0] w_ram_dia;
  logic [data_bits-1:0] w_ram_dob;

  assign w_clear  = (r_state == NB_CLEAR);
  // A clear request in IDLE takes priority over any same-cycle access.
  assign w_wr_acc = !w_clear && !clr_start && wr_en;
  assign w_rd_acc = !w_clear && !clr_start && rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= NB_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      NB_CLEAR: begin
        if (clr_start) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == {addr_bits{1'b1}}) begin
          w_state_nxt = NB_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      NB_IDLE: begin
        if (clr_start) begin
          w_state_nxt = NB_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = NB_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_fwd      <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      r_fwd      <= w_rd_acc && w_wr_acc && (rd_addr == wr_addr);
      r_fwd_data <= wr_data;
    end
  end

  assign w_ram_we    = w_clear || w_wr_acc;
  assign w_ram_addra = w_clear ? r_cnt : wr_addr;
  assign w_ram_dia   = w_clear ? clear_val : wr_data;

  ram_simple_dual #(
    .addr_bits (addr_bits),
    .data_bits (data_bits)
  ) u_ram (
    .clk   (clk),
    .en    (1'b1),
    .we    (w_ram_we),
    .addra (w_ram_addra),
    .addrb (rd_addr),
    .dia   (w_ram_dia),
    .dob   (w_ram_dob)
  );

  assign busy     = w_clear;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_fwd ? r_fwd_data : w_ram_dob;

endmodule

// File: tb/tb_nb_info_line_buf.sv
// tb/tb_nb_info_line_buf.sv - self-checking bench for nb_info_line_buf against a behavioural line model
module tb_nb_info_line_buf;

  localparam int          AB = 4;
  localparam int          DB = 16;
  localparam int          N  = 1 << AB;
  localparam logic [15:0] CV = 16'h0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start;
  logic          busy;
  logic          wr_en;
  logic [AB-1:0] wr_addr;
  logic [DB-1:0] wr_data;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic          rd_valid;
  logic [DB-1:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_mem [N];
  int          m_busy_left;
  bit          m_valid;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  nb_info_line_buf #(
    .addr_bits (AB),
    .data_bits (DB),
    .clear_val (CV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear_all();
    for (int i = 0; i < N; i++) m_mem[i] = CV;
  endtask

  // One clock of stimulus; the model is applied to the inputs, then outputs are sampled at the next negedge.
  task automatic cyc(input bit c, input bit w, input int wa, input logic [15:0] wd,
                     input bit r, input int ra);
    clr_start = c;
    wr_en     = w;
    wr_addr   = AB'(wa);
    wr_data   = wd;
    rd_en     = r;
    rd_addr   = AB'(ra);
    if (m_busy_left > 0) begin
      m_valid = 1'b0;
      if (c) m_busy_left = N;
      else   m_busy_left--;
    end else if (c) begin
      m_busy_left = N;
      m_valid     = 1'b0;
      model_clear_all();
    end else begin
      if (w) m_mem[wa] = wd;
      m_valid = r;
      if (r) m_data = m_mem[ra];
    end
    @(posedge clk);
    @(negedge clk);
    check("busy", {31'd0, busy}, {31'd0, (m_busy_left > 0)});
    check("rd_valid", {31'd0, rd_valid}, {31'd0, m_valid});
    if (m_valid) check("rd_data", {16'd0, rd_data}, {16'd0, m_data});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 16'h0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; the effect must be visible before any clock.
  task automatic do_reset();
    clr_start = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst         = 1'b0;
    m_busy_left = N;
    m_valid     = 1'b0;
    model_clear_all();
    #1;
    check("rel_busy", {31'd0, busy}, 32'd1);
  endtask

  initial begin
    int nb;
    rst       = 1'b1;
    clr_start = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
    rst         = 1'b0;
    m_busy_left = N;
    model_clear_all();
    nb = busy ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      idle();
      if (busy) nb++;
    end
    check("busy_len_reset", nb, N);

    for (int i = 0; i < N; i++) cyc(0, 0, 0, 16'h0, 1, i);
    idle();

    cyc(0, 1, 3, 16'hA5A5, 0, 0);
    cyc(0, 0, 0, 16'h0, 1, 3);
    check("raw_3", {16'd0, rd_data}, 32'hA5A5);
    idle();

    cyc(0, 1, 7, 16'h1234, 1, 7);
    check("bypass_7", {16'd0, rd_data}, 32'h1234);
    cyc(0, 0, 0, 16'h0, 1, 7);
    check("reread_7", {16'd0, rd_data}, 32'h1234);
    idle();

    nb = 0;
    for (int i = 0; i < N; i++) begin
      cyc(0, (i == 5), 5, 16'hBEEF, 1, i);
      if (rd_valid) nb++;
      if (i == 5) check("stream_5", {16'd0, rd_data}, 32'hBEEF);
    end
    check("stream_valid_cnt", nb, N);
    idle();

    cyc(1, 1, 2, 16'h7777, 1, 2);
    check("clr_drop_valid", {31'd0, rd_valid}, 32'd0);
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (busy) nb++;
    end
    check("busy_len_clr", nb, N);
    cyc(0, 0, 0, 16'h0, 1, 2);
    check("clr_2", {16'd0, rd_data}, {16'd0, CV});
    idle();

    cyc(1, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 9; i++) idle();
    cyc(1, 0, 0, 16'h0, 0, 0);
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (busy) nb++;
    end
    check("busy_len_restart", nb, N);

    for (int i = 0; i < 8; i++) cyc(0, 1, i, 16'h1000 + 16'(i), 0, 0);
    cyc(1, 0, 0, 16'h0, 0, 0);
    repeat (5) idle();
    do_reset();
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (busy) nb++;
    end
    check("busy_len_rst_mid", nb, N);

    cyc(0, 1, 9, 16'h4321, 0, 0);
    cyc(0, 0, 0, 16'h0, 1, 9);
    do_reset();
    repeat (20) idle();
    for (int i = 0; i < N; i++) cyc(0, 0, 0, 16'h0, 1, i);

    for (int k = 0; k < 800; k++) begin
      bit c, w, r;
      c = ($urandom % 50) == 0;
      w = $urandom % 2;
      r = ($urandom % 4) != 0;
      if (($urandom % 300) == 0) do_reset();
      else cyc(c, w, $urandom % N, 16'($urandom), r, $urandom % N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
